// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline stage with a main and a skid register.
// in_ready depends only on state flops plus reset/flush, so no in->out combinational path exists.
module pipe_skid_reg #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic [1:0]   count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic [n-1:0] main_reg, main_next;
    logic [n-1:0] skid_reg, skid_next;
    logic         in_fire, out_fire;

    always_comb begin
        out_valid = (state_reg == ONE) || (state_reg == TWO);
        in_ready  = ((state_reg == EMPTY) || (state_reg == ONE)) && !reset && !flush;
        out_data  = main_reg;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        case (state_reg)
            ONE:     count = 2'd1;
            TWO:     count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    state_next = ONE;
                    main_next  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_next = in_data;
                end else if (in_fire) begin
                    state_next = TWO;
                    skid_next  = in_data;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // Skid word moves up so arrival order is preserved.
                if (out_fire) begin
                    state_next = ONE;
                    main_next  = skid_reg;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only validity is dropped.
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed phases plus a random-stall run.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pipe_skid_reg #(.n(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected words come from what the bench itself offered and saw accepted.
    always @(negedge clk) begin
        if (in_valid && in_ready && !reset && !flush)
            exp_q.push_back(in_data);
    end

    // Monitor: pops on every output handshake and checks stall stability.
    logic        prev_stall = 1'b0;
    logic        prev_rf    = 1'b0;
    logic [31:0] prev_data  = '0;
    always @(negedge clk) begin
        if (prev_stall && !prev_rf) begin
            checks++;
            if (!out_valid || out_data !== prev_data) begin
                errors++;
                $display("FAIL stall_stable: got valid=%b data=%h expected valid=1 data=%h at %0t",
                         out_valid, out_data, prev_data, $time);
            end
        end
        if (out_valid && out_ready && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: got unexpected word %h expected none at %0t", out_data, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got %h expected %h at %0t", out_data, e, $time);
                end else begin
                    $display("out  %h at %0t", out_data, $time);
                end
            end
        end
        if (reset || flush)
            exp_q.delete();
        prev_stall = out_valid && !out_ready;
        prev_rf    = reset || flush;
        prev_data  = out_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_count", {30'd0, count}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        @(negedge clk);
        check("rel_count", {30'd0, count}, 32'd0);

        // Pass-through: each word visible one cycle after its handshake.
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            @(negedge clk);
            check("pt_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 1) begin
                check("pt_data", out_data, i - 1);
                check("pt_count", {30'd0, count}, 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pt_last", out_data, 32'd8);
        tick();
        @(negedge clk);
        check("pt_drain_count", {30'd0, count}, 32'd0);

        // Backpressure fills the skid register.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA5A5A5A5; tick();
        in_data = 32'h5A5A5A5A; tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_count", {30'd0, count}, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_data", out_data, 32'hA5A5A5A5);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_data_hold", out_data, 32'hA5A5A5A5);
        tick();
        @(negedge clk);
        check("bp_data2", out_data, 32'h5A5A5A5A);
        check("bp_count1", {30'd0, count}, 32'd1);
        check("bp_in_ready1", {31'd0, in_ready}, 32'd1);
        tick();
        @(negedge clk);
        check("bp_count0", {30'd0, count}, 32'd0);

        // Flush from TWO with a word offered at the same time.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11111111; tick();
        in_data = 32'h22222222; tick();
        flush = 1'b1; in_data = 32'h12345678;
        @(negedge clk);
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", {31'd0, out_valid}, 32'd0);
        check("fl_count", {30'd0, count}, 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("fl_stay_empty", {30'd0, count}, 32'd0);

        // Reset pulse while holding one stalled word.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h77777777; tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("mr_count1", {30'd0, count}, 32'd1);
        tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        @(negedge clk);
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_out_data", out_data, 32'd0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Random stall traffic.
        for (int c = 0; c < 1000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("end_count", {30'd0, count}, 32'd0);
        check("end_queue", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
